// File: rtl/sl_preceptron_pkg.sv
// Shared sl_preceptron constants and types.
// Holds the vector-TX FSM encoding and the default lane/width/length values.
package sl_preceptron_pkg;

   localparam int unsigned SL_LANES   = 4;
   localparam int unsigned SL_WIDTH   = 8;
   localparam int unsigned SL_VEC_LEN = 64;
   localparam int unsigned SL_GAP_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PACK = 2'd1,
      ST_GAP  = 2'd2
   } vec_tx_state_e;

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sl_preceptron_vec_tx.sv
// Packs a stream of elements into multi-lane beats forming fixed-length vectors.
// Ports: clk/rst_n, s_valid/s_data/s_ready in, abort, cfg_gap, beat outputs, vec_count.
module sl_preceptron_vec_tx
   import sl_preceptron_pkg::*;
#(
   parameter int unsigned DATA_IN_LANES = SL_LANES,
   parameter int unsigned DATA_IN_WIDTH = SL_WIDTH,
   parameter int unsigned VECTOR_LENGTH = SL_VEC_LEN,
   parameter int unsigned GAP_WIDTH     = SL_GAP_W
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   s_valid,
   input  logic [DATA_IN_WIDTH-1:0]               s_data,
   output logic                                   s_ready,
   input  logic                                   abort,
   input  logic [GAP_WIDTH-1:0]                   cfg_gap,
   output logic                                   data_valid,
   output logic [DATA_IN_WIDTH*DATA_IN_LANES-1:0] data_in,
   output logic                                   vec_start,
   output logic                                   vec_done,
   output logic [15:0]                            vec_count
);

   localparam int unsigned BEATS  = VECTOR_LENGTH / DATA_IN_LANES;
   localparam int unsigned FW     = cnt_w(DATA_IN_LANES);
   localparam int unsigned BW     = cnt_w(BEATS);
   localparam int unsigned BEAT_W = DATA_IN_WIDTH * DATA_IN_LANES;

   localparam logic [FW-1:0]        FILL_LAST = FW'(DATA_IN_LANES - 1);
   localparam logic [BW-1:0]        BEAT_LAST = BW'(BEATS - 1);
   localparam logic [GAP_WIDTH-1:0] GAP_ONE   = GAP_WIDTH'(1);

   vec_tx_state_e        state_q, state_d;
   logic [FW-1:0]        fill_q, fill_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic [GAP_WIDTH-1:0] gap_q, gap_d;
   logic [BEAT_W-1:0]    buf_q, buf_d;
   logic [BEAT_W-1:0]    din_q, din_d;
   logic                 dv_q, dv_d;
   logic                 vs_q, vs_d;
   logic                 vd_q, vd_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 accept;
   logic                 beat_full;

   // Abort blocks acceptance outright so the coincident element is dropped.
   assign s_ready   = (state_q != ST_GAP);
   assign accept    = s_valid && s_ready && !abort;
   assign beat_full = accept && (fill_q == FILL_LAST);

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      buf_d   = buf_q;
      din_d   = din_q;
      dv_d    = 1'b0;
      vs_d    = 1'b0;
      vd_d    = 1'b0;
      cnt_d   = cnt_q;

      if (accept) begin
         buf_d[fill_q*DATA_IN_WIDTH +: DATA_IN_WIDTH] = s_data;
         fill_d = fill_q + 1'b1;
      end

      // The completed beat includes the element arriving this cycle.
      if (beat_full) begin
         fill_d = '0;
         din_d  = buf_d;
         dv_d   = 1'b1;
         vs_d   = (beat_q == '0);
         vd_d   = (beat_q == BEAT_LAST);
         if (vd_d) begin
            beat_d = '0;
            cnt_d  = cnt_q + 16'd1;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_PACK;
         end
         ST_PACK: begin
            // Gap length is captured in the vec_done cycle only.
            if (vd_q) begin
               if (cfg_gap != '0) begin
                  state_d = ST_GAP;
                  gap_d   = cfg_gap;
               end else if (!accept) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_q <= GAP_ONE) begin
               state_d = ST_IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d = ST_IDLE;
         fill_d  = '0;
         beat_d  = '0;
         gap_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fill_q  <= '0;
         beat_q  <= '0;
         gap_q   <= '0;
         buf_q   <= '0;
         din_q   <= '0;
         dv_q    <= 1'b0;
         vs_q    <= 1'b0;
         vd_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         buf_q   <= buf_d;
         din_q   <= din_d;
         dv_q    <= dv_d;
         vs_q    <= vs_d;
         vd_q    <= vd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data_valid = dv_q;
   assign data_in    = din_q;
   assign vec_start  = vs_q;
   assign vec_done   = vd_q;
   assign vec_count  = cnt_q;

endmodule

// File: tb/tb_sl_preceptron_vec_tx.sv
// Self-checking bench for sl_preceptron_vec_tx.
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_sl_preceptron_vec_tx;

   localparam int LANES = 4;
   localparam int W     = 8;
   localparam int VLEN  = 64;
   localparam int GW    = 4;
   localparam int BEATS = VLEN / LANES;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          s_valid = 1'b0;
   logic [W-1:0]  s_data = '0;
   logic          s_ready;
   logic          abort = 1'b0;
   logic [GW-1:0] cfg_gap = '0;
   logic          data_valid;
   logic [31:0]   data_in;
   logic          vec_start;
   logic          vec_done;
   logic [15:0]   vec_count;

   int chk = 0;
   int err = 0;

   sl_preceptron_vec_tx #(
      .DATA_IN_LANES(LANES),
      .DATA_IN_WIDTH(W),
      .VECTOR_LENGTH(VLEN),
      .GAP_WIDTH(GW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .abort(abort),
      .cfg_gap(cfg_gap),
      .data_valid(data_valid),
      .data_in(data_in),
      .vec_start(vec_start),
      .vec_done(vec_done),
      .vec_count(vec_count)
   );

   always #5 clk = ~clk;

   // Reference model: elements collect in a queue, a full queue is one beat.
   logic [W-1:0] m_lanes[$];
   int           m_beat;
   int           m_gap;
   logic         m_dv, m_vs, m_vd, m_rdy, m_acc, m_was_vd;
   logic [15:0]  m_cnt;
   logic [31:0]  m_din;

   always begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_lanes.delete();
         m_beat = 0;
         m_gap  = 0;
         m_dv   = 1'b0;
         m_vs   = 1'b0;
         m_vd   = 1'b0;
         m_rdy  = 1'b1;
         m_cnt  = '0;
         m_din  = '0;
      end else begin
         m_acc    = s_valid && m_rdy && !abort;
         m_was_vd = m_vd;
         m_dv = 1'b0;
         m_vs = 1'b0;
         m_vd = 1'b0;
         if (abort) begin
            m_lanes.delete();
            m_beat = 0;
            m_gap  = 0;
         end else begin
            if (m_was_vd) m_gap = int'(cfg_gap);
            else if (m_gap > 0) m_gap--;
            if (m_acc) begin
               m_lanes.push_back(s_data);
               if (m_lanes.size() == LANES) begin
                  for (int k = 0; k < LANES; k++) m_din[k*W +: W] = m_lanes[k];
                  m_lanes.delete();
                  m_dv = 1'b1;
                  m_vs = (m_beat == 0);
                  m_vd = (m_beat == BEATS - 1);
                  m_beat = (m_beat + 1) % BEATS;
                  if (m_vd) m_cnt++;
               end
            end
         end
         m_rdy = (m_gap == 0);
      end
   end

   task automatic apply_reset();
      s_valid = 1'b0;
      abort   = 1'b0;
      s_data  = '0;
      rst_n   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      chk++;
      if ({data_valid, vec_start, vec_done, vec_count, data_in} !== '0) begin
         err++;
         $display("FAIL reset outs got %h exp 0",
                  {data_valid, vec_start, vec_done, vec_count, data_in});
      end
      chk++;
      if (s_ready !== 1'b1) begin
         err++;
         $display("FAIL reset s_ready got %b exp 1", s_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_vector();
      int nb = 0;
      apply_reset();
      cfg_gap = '0;
      for (int i = 0; i < 68; i++) begin
         s_valid = (i < 64);
         s_data  = W'(i);
         @(negedge clk);
         chk++;
         if ({data_valid, vec_start, vec_done, s_ready, vec_count, data_in} !==
             {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din}) begin
            err++;
            $display("FAIL vector cyc %0d got %h exp %h", i,
                     {data_valid, vec_start, vec_done, s_ready, vec_count, data_in},
                     {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din});
         end
         if (data_valid === 1'b1) begin
            if (nb == 0) begin
               chk++;
               if (data_in !== 32'h03020100 || vec_start !== 1'b1) begin
                  err++;
                  $display("FAIL vector beat0 got %h vs %b exp 03020100 vs 1",
                           data_in, vec_start);
               end
            end
            if (nb == 15) begin
               chk++;
               if (data_in !== 32'h3F3E3D3C || vec_done !== 1'b1) begin
                  err++;
                  $display("FAIL vector beat15 got %h vd %b exp 3f3e3d3c vd 1",
                           data_in, vec_done);
               end
            end
            nb++;
         end
      end
      s_valid = 1'b0;
      chk++;
      if (nb != 16) begin
         err++;
         $display("FAIL vector beats got %0d exp 16", nb);
      end
      chk++;
      if (vec_count !== 16'd1) begin
         err++;
         $display("FAIL vector count got %0d exp 1", vec_count);
      end
   endtask

   task automatic test_gap();
      int done = 0;
      int low  = 0;
      int i    = 0;
      apply_reset();
      cfg_gap = 4'd3;
      s_valid = 1'b1;
      while (done < 2 && i < 400) begin
         s_data = W'($urandom);
         @(negedge clk);
         chk++;
         if ({data_valid, vec_start, vec_done, s_ready, vec_count, data_in} !==
             {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din}) begin
            err++;
            $display("FAIL gap cyc %0d got %h exp %h", i,
                     {data_valid, vec_start, vec_done, s_ready, vec_count, data_in},
                     {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din});
         end
         if (done == 1 && s_ready === 1'b0) begin
            low++;
            cfg_gap = 4'd9;
         end
         if (vec_done === 1'b1) done++;
         i++;
      end
      s_valid = 1'b0;
      cfg_gap = '0;
      chk++;
      if (done < 2) begin
         err++;
         $display("FAIL gap timeout vectors got %0d exp 2", done);
      end
      chk++;
      if (low != 3) begin
         err++;
         $display("FAIL gap ready_low got %0d exp 3", low);
      end
      chk++;
      if (vec_count !== 16'd2) begin
         err++;
         $display("FAIL gap count got %0d exp 2", vec_count);
      end
   endtask

   task automatic test_toggle();
      int last = -1;
      int nb   = 0;
      apply_reset();
      cfg_gap = '0;
      for (int i = 0; i < 132; i++) begin
         s_valid = (i % 2 == 0) && (i < 128);
         s_data  = W'($urandom);
         @(negedge clk);
         chk++;
         if ({data_valid, vec_start, vec_done, s_ready, vec_count, data_in} !==
             {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din}) begin
            err++;
            $display("FAIL toggle cyc %0d got %h exp %h", i,
                     {data_valid, vec_start, vec_done, s_ready, vec_count, data_in},
                     {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din});
         end
         if (data_valid === 1'b1) begin
            if (last >= 0) begin
               chk++;
               if (i - last != 8) begin
                  err++;
                  $display("FAIL toggle spacing got %0d exp 8", i - last);
               end
            end
            last = i;
            nb++;
         end
      end
      s_valid = 1'b0;
      chk++;
      if (nb != 16 || vec_count !== 16'd1) begin
         err++;
         $display("FAIL toggle totals got beats %0d cnt %0d exp 16 1", nb, vec_count);
      end
   endtask

   task automatic test_abort();
      int vd_pre = 0;
      int first  = 1;
      apply_reset();
      cfg_gap = '0;
      for (int i = 0; i < 22; i++) begin
         s_valid = 1'b1;
         s_data  = W'(i);
         @(negedge clk);
         if (vec_done === 1'b1) vd_pre++;
      end
      s_valid = 1'b0;
      abort   = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk++;
      if (vd_pre != 0 || data_valid !== 1'b0) begin
         err++;
         $display("FAIL abort pre got vd %0d dv %b exp 0 0", vd_pre, data_valid);
      end
      for (int i = 0; i < 68; i++) begin
         s_valid = (i < 64);
         s_data  = W'(8'h40 + i);
         @(negedge clk);
         chk++;
         if ({data_valid, vec_start, vec_done, s_ready, vec_count, data_in} !==
             {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din}) begin
            err++;
            $display("FAIL abort cyc %0d got %h exp %h", i,
                     {data_valid, vec_start, vec_done, s_ready, vec_count, data_in},
                     {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din});
         end
         if (data_valid === 1'b1 && first == 1) begin
            first = 0;
            chk++;
            if (data_in !== 32'h43424140 || vec_start !== 1'b1) begin
               err++;
               $display("FAIL abort beat0 got %h vs %b exp 43424140 vs 1",
                        data_in, vec_start);
            end
         end
      end
      s_valid = 1'b0;
      chk++;
      if (vec_count !== 16'd1) begin
         err++;
         $display("FAIL abort count got %0d exp 1", vec_count);
      end
   endtask

   task automatic test_midreset();
      int nb  = 0;
      int hit = 0;
      int first = 1;
      apply_reset();
      cfg_gap = '0;
      for (int i = 0; i < 100 && hit == 0; i++) begin
         s_valid = 1'b1;
         s_data  = W'(i);
         @(negedge clk);
         if (data_valid === 1'b1) begin
            if (nb == 7) hit = 1;
            nb++;
         end
      end
      chk++;
      if (hit == 0) begin
         err++;
         $display("FAIL midreset timeout beats got %0d exp 8", nb);
      end
      #2 rst_n = 1'b0;
      #1;
      chk++;
      if ({data_valid, vec_start, vec_done, vec_count, data_in} !== '0) begin
         err++;
         $display("FAIL midreset outs got %h exp 0",
                  {data_valid, vec_start, vec_done, vec_count, data_in});
      end
      s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 68; i++) begin
         s_valid = (i < 64);
         s_data  = W'($urandom);
         @(negedge clk);
         chk++;
         if ({data_valid, vec_start, vec_done, s_ready, vec_count, data_in} !==
             {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din}) begin
            err++;
            $display("FAIL midreset cyc %0d got %h exp %h", i,
                     {data_valid, vec_start, vec_done, s_ready, vec_count, data_in},
                     {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din});
         end
         if (data_valid === 1'b1 && first == 1) begin
            first = 0;
            chk++;
            if (vec_start !== 1'b1) begin
               err++;
               $display("FAIL midreset start got %b exp 1", vec_start);
            end
         end
      end
      s_valid = 1'b0;
      chk++;
      if (vec_count !== 16'd1) begin
         err++;
         $display("FAIL midreset count got %0d exp 1", vec_count);
      end
   endtask

   task automatic test_abort_coincide();
      logic [W-1:0] d[4];
      apply_reset();
      cfg_gap = '0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = W'($urandom);
         @(negedge clk);
      end
      s_data = W'($urandom);
      abort  = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk++;
      if (data_valid !== 1'b0) begin
         err++;
         $display("FAIL coincide dv got %b exp 0", data_valid);
      end
      for (int j = 0; j < 4; j++) begin
         d[j]    = W'($urandom);
         s_data  = d[j];
         s_valid = 1'b1;
         @(negedge clk);
         if (j < 3) begin
            chk++;
            if (data_valid !== 1'b0) begin
               err++;
               $display("FAIL coincide early dv at %0d got %b exp 0", j, data_valid);
            end
         end else begin
            chk++;
            if (data_valid !== 1'b1 || vec_start !== 1'b1 ||
                data_in !== {d[3], d[2], d[1], d[0]}) begin
               err++;
               $display("FAIL coincide beat got dv %b vs %b %h exp 1 1 %h",
                        data_valid, vec_start, data_in, {d[3], d[2], d[1], d[0]});
            end
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = W'($urandom);
         abort   = ($urandom_range(0, 150) == 0);
         cfg_gap = GW'($urandom_range(0, 5));
         @(negedge clk);
         chk++;
         if ({data_valid, vec_start, vec_done, s_ready, vec_count, data_in} !==
             {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din}) begin
            err++;
            $display("FAIL b2b cyc %0d got %h exp %h", i,
                     {data_valid, vec_start, vec_done, s_ready, vec_count, data_in},
                     {m_dv, m_vs, m_vd, m_rdy, m_cnt, m_din});
         end
      end
      s_valid = 1'b0;
      abort   = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vector();
      test_gap();
      test_toggle();
      test_abort();
      test_midreset();
      test_abort_coincide();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule

// File: doc/sl_preceptron_vec_tx.md
SL_PRECEPTRON_VEC_TX -- requirements
Module: sl_preceptron_vec_tx

Interface
REQ-001 SHALL have parameter DATA_IN_LANES, default 4, lanes per output beat.
REQ-002 SHALL have parameter DATA_IN_WIDTH, default 8, bits per lane.
REQ-003 SHALL have parameter VECTOR_LENGTH, default 64, elements per vector; must be a multiple of DATA_IN_LANES.
REQ-004 SHALL have parameter GAP_WIDTH, default 4, width of cfg_gap.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port s_valid, input, 1, upstream element valid.
REQ-008 SHALL have port s_data, input, DATA_IN_WIDTH, upstream element.
REQ-009 SHALL have port s_ready, output, 1, element accepted when s_valid && s_ready.
REQ-010 SHALL have port abort, input, 1, synchronous discard of the partial vector.
REQ-011 SHALL have port cfg_gap, input, GAP_WIDTH, idle cycles inserted after each vector.
REQ-012 SHALL have port data_valid, output, 1, beat strobe toward the perceptron receiver.
REQ-013 SHALL have port data_in, output, DATA_IN_WIDTH*DATA_IN_LANES, packed beat.
REQ-014 SHALL have port vec_start, output, 1, pulse on the first beat of a vector.
REQ-015 SHALL have port vec_done, output, 1, pulse on the last beat of a vector.
REQ-016 SHALL have port vec_count, output, 16, completed vectors, wraps mod 2^16.

Function
REQ-017 SHALL implement FSM states IDLE, PACK and GAP.
REQ-018 SHALL move IDLE->PACK on the first accepted element, PACK->GAP after the last beat of a vector when cfg_gap!=0, PACK->IDLE after the last beat when cfg_gap==0, and GAP->IDLE after cfg_gap cycles.
REQ-019 SHALL drive s_ready=1 in IDLE and PACK and s_ready=0 in GAP.
REQ-020 SHALL place the k-th accepted element of a beat in lane k (bits k*DATA_IN_WIDTH+:DATA_IN_WIDTH); lane 0 is the first element.
REQ-021 SHALL assert data_valid for exactly one cycle, the cycle after the DATA_IN_LANES-th element of a beat is accepted; data_in is registered and valid only while data_valid=1.
REQ-022 SHALL hold data_in at its last value when data_valid=0; the downstream side has no backpressure.
REQ-023 SHALL emit VECTOR_LENGTH/DATA_IN_LANES beats per vector (16 at defaults) with a beat counter that wraps to 0 after the last beat.
REQ-024 SHALL assert vec_start together with data_valid for beat 0, and vec_done together with data_valid for the last beat.
REQ-025 SHALL increment vec_count in the vec_done cycle.
REQ-026 SHALL sample cfg_gap on the vec_done cycle; changes during GAP have no effect.
REQ-027 SHALL, on abort=1, clear the lane fill count and beat counter, enter IDLE, suppress data_valid/vec_start/vec_done that cycle, and leave vec_count unchanged.
REQ-028 SHALL give abort priority over a simultaneous element acceptance; that element is discarded.
REQ-029 SHALL not accept elements while abort=1 (s_ready still reflects state; the accepted element is discarded).

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state=IDLE, data_valid=0, vec_start=0, vec_done=0, data_in=0, vec_count=0, and fill/beat/gap counters=0.
REQ-031 SHALL discard any partial vector on reset mid-operation and restart at beat 0.

Structure
REQ-032 SHALL take the FSM state encoding and default lane/width/length constants from the shared sl_preceptron package, used with sl_preceptron_top.
REQ-033 SHALL be a single module with no sub-modules; the lane packer is inline.

Verification
REQ-034 SHALL cover: 64 back-to-back elements 0x00..0x3F, cfg_gap=0 -> 16 beats, beat 0 data_in=0x03020100, beat 15=0x3F3E3D3C, vec_start on beat 0, vec_done on beat 15, vec_count=1.
REQ-035 SHALL cover: cfg_gap=3, two vectors -> s_ready low exactly 3 cycles after the first vec_done, vec_count=2.
REQ-036 SHALL cover: s_valid toggling every other cycle -> beats spaced 8 cycles apart, lane order preserved.
REQ-037 SHALL cover: abort after 22 elements, then 64 elements 0x40..0x7F -> no vec_done before abort, new beat 0 data_in=0x43424140, vec_count=1.
REQ-038 SHALL cover: rst_n low during beat 7 -> outputs zero immediately, next vector starts at beat 0 with vec_start.
REQ-039 SHALL cover: abort coincident with the 4th element of a beat -> no data_valid, element discarded.
